fetch_fd_stage: RTL

Fetch stage of the 5-stage RV32I pipeline: owns the program counter, drives the synchronous instruction memory, and holds the F/D pipeline register that feeds the decoder and control unit ahead of the D/E control register. It applies hazard-unit stalls and flushes and takes PC redirects resolved in Execute. It also provides a fetched-instruction counter and a sticky misaligned-target flag.

---
 rtl/fetch_fd_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_fd_stage.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory and
// holds the F/D pipeline register with stall, flush and redirect handling.
module fetch_fd_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Clear,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_redirect_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    state_e      state_q;
    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic [31:0] pc_f_plus4;
    logic [31:0] tgt;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [31:0] count_q;
    logic        misalign_q;
    logic        fd_bubble;
    logic        fd_load;
    logic        unused_tgt_bit0;

    // Bit 0 is dropped silently, as JALR clears it architecturally.
    assign unused_tgt_bit0 = pc_target_e[0];
    assign tgt             = {pc_target_e[31:2], 2'b00};
    assign pc_f_plus4      = pc_f_q + 32'd4;

    always_comb begin
        pc_f_d = pc_f_plus4;
        if (pc_redirect_e) begin
            pc_f_d = tgt;
        end else if (stall_f || state_q == BOOT) begin
            pc_f_d = pc_f_q;
        end
    end

    assign imem_addr = pc_f_d;
    assign fd_bubble = flush_d || (state_q == BOOT);
    assign fd_load   = !fd_bubble && !stall_f;

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state_q <= BOOT;
            pc_f_q  <= RESET_PC;
        end else begin
            state_q <= RUN;
            pc_f_q  <= pc_f_d;
        end
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (fd_bubble) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (fd_load) begin
            instr_q <= imem_rdata;
            pc_q    <= pc_f_q;
            pc4_q   <= pc_f_plus4;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            if (fd_load) begin
                count_q <= count_q + 32'd1;
            end
            if (pc_redirect_e && pc_target_e[1]) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign instr_d      = instr_q;
    assign pc_d         = pc_q;
    assign pc_plus4_d   = pc4_q;
    assign valid_d      = valid_q;
    assign fetch_count  = count_q;
    assign misalign_err = misalign_q;

endmodule
